// File: rtl/data_sync_launcher_pkg.sv
// Shared definitions for the source-side CDC bus launcher: FSM encodings and
// the width rule for the ack-timeout counter.
package data_sync_launcher_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_RELEASE = 2'b10
   } state_t;

   // A timeout of 0 disables the counter, but it still needs one bit to exist.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/data_sync_launcher_if.sv
// Handshake and launched-bus signals between a bridge, the launcher and the
// destination-domain synchronizer.
interface data_sync_launcher_if #(
   parameter int BUS_WIDTH = 8
) ();
   logic [BUS_WIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 ack_async;
   logic [BUS_WIDTH-1:0] unsync_bus;
   logic                 bus_enable;
   logic                 busy;
   logic                 done;
   logic                 timeout_err;

   // master: the launcher itself; slave: the bridge and destination side
   modport master (
      input  in_data, in_valid, ack_async,
      output in_ready, unsync_bus, bus_enable, busy, done, timeout_err
   );

   modport slave (
      output in_data, in_valid, ack_async,
      input  in_ready, unsync_bus, bus_enable, busy, done, timeout_err
   );
endinterface

// File: rtl/data_sync_launcher_ack_bit_sync.sv
// Multi-flop synchronizer bringing the destination's level ack into CLK.
module data_sync_launcher_ack_bit_sync #(
   parameter int NUM_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic ack_async,
   output logic ack_sync
);
   logic [NUM_STAGES-1:0] chain;

   always_ff @(posedge CLK) begin
      if (RST) begin
         chain <= '0;
      end else begin
         chain <= {chain[NUM_STAGES-2:0], ack_async};
      end
   end

   assign ack_sync = chain[NUM_STAGES-1];
endmodule

// File: rtl/data_sync_launcher.sv
// Source-domain end of a four-phase multi-bit CDC: holds a captured word on
// unsync_bus, raises bus_enable, and waits for the synchronized ack to rise and fall.
module data_sync_launcher
   import data_sync_launcher_pkg::*;
#(
   parameter int BUS_WIDTH   = 8,
   parameter int NUM_STAGES  = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input logic             CLK,
   input logic             RST,
   data_sync_launcher_if.master bus
);
   localparam int             CNT_W    = cnt_width(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam bit             TO_EN    = (ACK_TIMEOUT != 0);

   state_t               state, state_nxt;
   logic [BUS_WIDTH-1:0] data_q, data_nxt;
   logic [CNT_W-1:0]     cnt_q, cnt_nxt;
   logic                 be_q, be_nxt;
   logic                 done_q, done_nxt;
   logic                 terr_q, terr_nxt;
   logic                 acked_q, acked_nxt;
   logic                 ack_sync;

   data_sync_launcher_ack_bit_sync #(
      .NUM_STAGES (NUM_STAGES)
   ) ack_bit_sync (
      .CLK       (CLK),
      .RST       (RST),
      .ack_async (bus.ack_async),
      .ack_sync  (ack_sync)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // acked_q remembers whether REQ ended by ack, so only real transfers report done.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      cnt_nxt   = cnt_q;
      be_nxt    = be_q;
      acked_nxt = acked_q;
      done_nxt  = 1'b0;
      terr_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_nxt = ST_REQ;
               data_nxt  = bus.in_data;
               be_nxt    = 1'b1;
               cnt_nxt   = '0;
               acked_nxt = 1'b0;
            end
         end
         ST_REQ: begin
            be_nxt = 1'b1;
            if (cnt_q != CNT_MAX) begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
            if (ack_sync) begin
               state_nxt = ST_RELEASE;
               be_nxt    = 1'b0;
               acked_nxt = 1'b1;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               state_nxt = ST_RELEASE;
               be_nxt    = 1'b0;
               terr_nxt  = 1'b1;
               acked_nxt = 1'b0;
            end
         end
         ST_RELEASE: begin
            be_nxt = 1'b0;
            if (!ack_sync) begin
               state_nxt = ST_IDLE;
               done_nxt  = acked_q;
               acked_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            be_nxt    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         data_q  <= '0;
         cnt_q   <= '0;
         be_q    <= 1'b0;
         done_q  <= 1'b0;
         terr_q  <= 1'b0;
         acked_q <= 1'b0;
      end else begin
         data_q  <= data_nxt;
         cnt_q   <= cnt_nxt;
         be_q    <= be_nxt;
         done_q  <= done_nxt;
         terr_q  <= terr_nxt;
         acked_q <= acked_nxt;
      end
   end

   assign bus.in_ready    = (state == ST_IDLE);
   assign bus.busy        = (state != ST_IDLE);
   assign bus.unsync_bus  = data_q;
   assign bus.bus_enable  = be_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_data_sync_launcher.sv
// Directed bench: a cycle table for handshake, backpressure and reset-in-REQ on
// a default launcher, plus hand sequences for timeout corners on a short-timeout one.
module tb_data_sync_launcher;
   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_t = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   data_sync_launcher_if #(.BUS_WIDTH(8)) ifa ();
   data_sync_launcher_if #(.BUS_WIDTH(8)) ift ();

   data_sync_launcher #(.BUS_WIDTH(8), .NUM_STAGES(2), .ACK_TIMEOUT(255)) dut_a (
      .CLK (clk),
      .RST (rst_a),
      .bus (ifa)
   );

   data_sync_launcher #(.BUS_WIDTH(8), .NUM_STAGES(2), .ACK_TIMEOUT(4)) dut_t (
      .CLK (clk),
      .RST (rst_t),
      .bus (ift)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] data;
      logic       ack;
      logic       rdy;
      logic       bsy;
      logic       be;
      logic [7:0] bus;
      logic       dn;
      logic       te;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic r, v, input logic [7:0] d, input logic a,
                               input logic rdy, bsy, be, input logic [7:0] b,
                               input logic dn, te);
      vec_t x;
      x.rst = r; x.vld = v; x.data = d; x.ack = a;
      x.rdy = rdy; x.bsy = bsy; x.be = be; x.bus = b; x.dn = dn; x.te = te;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step_a(input logic r, v, input logic [7:0] d, input logic a);
      @(negedge clk);
      rst_a = r; ifa.in_valid = v; ifa.in_data = d; ifa.ack_async = a;
      @(posedge clk);
      #1;
   endtask

   task automatic step_t(input logic r, v, input logic [7:0] d, input logic a);
      @(negedge clk);
      rst_t = r; ift.in_valid = v; ift.in_data = d; ift.ack_async = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int be_cycles;
      int terr_cnt;
      int done_cnt;
      bit seen_low;
      bit exited;
      logic terr_drop;
      logic done_drop;

      ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.ack_async = 1'b0;
      ift.in_valid = 1'b0; ift.in_data = 8'h00; ift.ack_async = 1'b0;

      //                 rst v  data  ack   rdy bsy be bus   dn te
      vq.push_back(mk(1, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0));
      vq.push_back(mk(1, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0));
      vq.push_back(mk(0, 1, 8'hA5, 0,   0, 1, 1, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 1, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 1, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 1, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 1, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   1, 0, 0, 8'hA5, 1, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   1, 0, 0, 8'hA5, 0, 0));
      vq.push_back(mk(0, 1, 8'h5A, 0,   0, 1, 1, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 1,   0, 1, 1, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 1,   0, 1, 1, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 1,   0, 1, 0, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 0,   0, 1, 0, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 0,   0, 1, 0, 8'h5A, 0, 0));
      vq.push_back(mk(0, 1, 8'h3C, 0,   1, 0, 0, 8'h5A, 1, 0));
      vq.push_back(mk(0, 1, 8'h3C, 0,   0, 1, 1, 8'h3C, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 1, 8'h3C, 0, 0));
      vq.push_back(mk(1, 0, 8'h00, 0,   1, 0, 0, 8'h00, 0, 0));
      vq.push_back(mk(0, 1, 8'hC3, 0,   0, 1, 1, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 1, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 1, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 1,   0, 1, 0, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 0, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   0, 1, 0, 8'hC3, 0, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   1, 0, 0, 8'hC3, 1, 0));
      vq.push_back(mk(0, 0, 8'h00, 0,   1, 0, 0, 8'hC3, 0, 0));

      for (int i = 0; i < vq.size(); i++) begin
         step_a(vq[i].rst, vq[i].vld, vq[i].data, vq[i].ack);
         check($sformatf("row%0d.in_ready", i),   32'(ifa.in_ready),    32'(vq[i].rdy));
         check($sformatf("row%0d.busy", i),       32'(ifa.busy),        32'(vq[i].bsy));
         check($sformatf("row%0d.bus_enable", i), 32'(ifa.bus_enable),  32'(vq[i].be));
         check($sformatf("row%0d.unsync_bus", i), 32'(ifa.unsync_bus),  32'(vq[i].bus));
         check($sformatf("row%0d.done", i),       32'(ifa.done),        32'(vq[i].dn));
         check($sformatf("row%0d.timeout_err", i),32'(ifa.timeout_err), 32'(vq[i].te));
      end

      // Timeout with ack tied low
      step_t(1, 0, 8'h00, 0);
      step_t(1, 0, 8'h00, 0);
      check("to.reset_ready", 32'(ift.in_ready), 32'(1));
      check("to.reset_be",    32'(ift.bus_enable), 32'(0));
      step_t(0, 1, 8'h96, 0);
      check("to.capture_be",  32'(ift.bus_enable), 32'(1));
      check("to.capture_bus", 32'(ift.unsync_bus), 32'(8'h96));
      be_cycles = 1;
      terr_cnt  = 0;
      done_cnt  = 0;
      seen_low  = 1'b0;
      terr_drop = 1'b0;
      done_drop = 1'b0;
      for (int i = 0; i < 20 && !seen_low; i++) begin
         step_t(0, 0, 8'h00, 0);
         if (ift.timeout_err) terr_cnt++;
         if (ift.done) done_cnt++;
         if (ift.bus_enable) be_cycles++;
         else begin
            seen_low  = 1'b1;
            terr_drop = ift.timeout_err;
            done_drop = ift.done;
         end
      end
      check("to.be_dropped",  32'(seen_low), 32'(1));
      check("to.be_cycles",   32'(be_cycles), 32'(4));
      check("to.err_at_drop", 32'(terr_drop), 32'(1));
      check("to.done_at_drop",32'(done_drop), 32'(0));
      check("to.busy_at_drop",32'(ift.busy), 32'(1));
      step_t(0, 0, 8'h00, 0);
      check("to.idle_next_busy",  32'(ift.busy), 32'(0));
      check("to.idle_next_ready", 32'(ift.in_ready), 32'(1));
      if (ift.timeout_err) terr_cnt++;
      if (ift.done) done_cnt++;
      for (int i = 0; i < 3; i++) begin
         step_t(0, 0, 8'h00, 0);
         if (ift.timeout_err) terr_cnt++;
         if (ift.done) done_cnt++;
      end
      check("to.err_pulses",  32'(terr_cnt), 32'(1));
      check("to.done_pulses", 32'(done_cnt), 32'(0));
      check("to.bus_held",    32'(ift.unsync_bus), 32'(8'h96));

      // Ack reaches ack_sync on the same cycle the timeout would fire
      step_t(0, 1, 8'h69, 0);
      check("co.capture_be", 32'(ift.bus_enable), 32'(1));
      step_t(0, 0, 8'h00, 0);
      step_t(0, 0, 8'h00, 1);
      step_t(0, 0, 8'h00, 1);
      check("co.still_req_be", 32'(ift.bus_enable), 32'(1));
      step_t(0, 0, 8'h00, 1);
      check("co.release_be",   32'(ift.bus_enable), 32'(0));
      check("co.release_err",  32'(ift.timeout_err), 32'(0));
      check("co.release_busy", 32'(ift.busy), 32'(1));
      terr_cnt = 0;
      done_cnt = 0;
      exited   = 1'b0;
      for (int i = 0; i < 12 && !exited; i++) begin
         step_t(0, 0, 8'h00, 0);
         if (ift.timeout_err) terr_cnt++;
         if (ift.done) done_cnt++;
         if (!ift.busy) exited = 1'b1;
      end
      check("co.exited",      32'(exited), 32'(1));
      check("co.done_pulses", 32'(done_cnt), 32'(1));
      check("co.err_pulses",  32'(terr_cnt), 32'(0));
      check("co.bus_held",    32'(ift.unsync_bus), 32'(8'h69));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
